mac_stream: RTL and testbench

//  Parametrised streaming MAC. TAPS-deep weight and feature shift windows; dot product of the

---
 rtl/mac_stream_pkg.sv | 23 ++
 rtl/mac_sum_tree.sv | 53 +++++
 rtl/mac_stream.sv | 142 ++++++++++++++
 tb/tb_mac_stream.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mac_stream_pkg.sv
// Shared definitions for the streaming MAC: default widths, a constant clog2 and the
// accumulator width derivation used by the top and the adder stage.
package mac_stream_pkg;

    localparam int DATA_BIT_DEF  = 32'sd16;
    localparam int TAPS_DEF      = 32'sd3;
    localparam int ACC_GUARD_DEF = 32'sd2;

    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        while ((32'sd1 <<< result) < value) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

    // Room for TAPS full-scale products plus 2^acc_guard windows of accumulation.
    function automatic int out_width(input int data_bit, input int taps, input int acc_guard);
        return 32'sd2 * data_bit + clog2(taps) + acc_guard;
    endfunction

endpackage

// File: rtl/mac_sum_tree.sv
// Registered TAPS-input signed adder; the register doubles as the accumulator that
// out reads from, so it keeps its value after a handoff.
module mac_sum_tree
    import mac_stream_pkg::*;
#(
    parameter int PW    = 32'sd32,
    parameter int TAPS  = TAPS_DEF,
    parameter int OUT_W = 32'sd36
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     clear_i,
    input  logic                     fire_i,
    input  logic                     acc_i,
    input  logic [TAPS-1:0][PW-1:0]  prod_i,
    output logic [OUT_W-1:0]         sum_o
);

    logic [OUT_W-1:0] sum_s;
    logic [OUT_W-1:0] acc_d;
    logic [OUT_W-1:0] acc_q;

    // Sign-extended sum of the products, then replace-or-accumulate selection.
    always_comb begin
        sum_s = {OUT_W{1'b0}};
        for (int i = 0; i < TAPS; i++) begin
            sum_s = sum_s + {{(OUT_W-PW){prod_i[i][PW-1]}}, prod_i[i]};
        end
        if (fire_i) begin
            if (acc_i) begin
                acc_d = acc_q + sum_s;
            end else begin
                acc_d = sum_s;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Result register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q <= {OUT_W{1'b0}};
        end else if (clear_i) begin
            acc_q <= {OUT_W{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

    assign sum_o = acc_q;

endmodule

// File: rtl/mac_stream.sv
// Streaming MAC: weight/feature shift windows, registered products, and a registered
// sum/accumulate stage with a valid/ready output that backpressures the feature input.
module mac_stream
    import mac_stream_pkg::*;
#(
    parameter  int DATA_BIT  = DATA_BIT_DEF,
    parameter  int TAPS      = TAPS_DEF,
    parameter  int ACC_GUARD = ACC_GUARD_DEF,
    localparam int OUT_W     = out_width(DATA_BIT, TAPS, ACC_GUARD)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                w_w,
    input  logic [DATA_BIT-1:0] w_in,
    input  logic                if_w,
    input  logic [DATA_BIT-1:0] if_in,
    input  logic                acc_en,
    output logic                if_rdy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out
);

    localparam int CNT_W = clog2(TAPS + 32'sd1);
    localparam int PW    = 32'sd2 * DATA_BIT;

    logic [TAPS-1:0][DATA_BIT-1:0] weight_q, weight_d;
    logic [TAPS-1:0][DATA_BIT-1:0] feature_q, feature_d;
    logic [CNT_W-1:0]              fill_q, fill_d;
    logic                          s0_valid_q, s0_valid_d;
    logic                          s0_acc_q, s0_acc_d;
    logic                          p_valid_q, p_valid_d;
    logic                          p_acc_q, p_acc_d;
    logic [TAPS-1:0][PW-1:0]       prod_q, prod_d;
    logic                          out_valid_q, out_valid_d;
    logic                          stall_s, accept_s, issue_s, fire_s;

    assign stall_s  = out_valid_q & ~out_ready;
    assign accept_s = if_w & ~stall_s;
    assign issue_s  = accept_s & (fill_q >= CNT_W'(TAPS - 32'sd1));
    assign fire_s   = p_valid_q & ~stall_s;

    // Shift windows and fill count; weights shift regardless of stall.
    always_comb begin
        if (w_w) begin
            weight_d = {weight_q[TAPS-2:0], w_in};
        end else begin
            weight_d = weight_q;
        end
        if (accept_s) begin
            feature_d = {feature_q[TAPS-2:0], if_in};
        end else begin
            feature_d = feature_q;
        end
        if (accept_s && (fill_q != CNT_W'(TAPS))) begin
            fill_d = fill_q + CNT_W'(1'b1);
        end else begin
            fill_d = fill_q;
        end
    end

    // Pipeline advance: everything holds while the result waits for the consumer.
    always_comb begin
        prod_d = prod_q;
        if (!stall_s) begin
            s0_valid_d = issue_s;
            s0_acc_d   = acc_en;
            p_valid_d  = s0_valid_q;
            p_acc_d    = s0_acc_q;
            for (int i = 0; i < TAPS; i++) begin
                prod_d[i] = $signed({{DATA_BIT{weight_q[i][DATA_BIT-1]}}, weight_q[i]}) *
                            $signed({{DATA_BIT{feature_q[i][DATA_BIT-1]}}, feature_q[i]});
            end
        end else begin
            s0_valid_d = s0_valid_q;
            s0_acc_d   = s0_acc_q;
            p_valid_d  = p_valid_q;
            p_acc_d    = p_acc_q;
        end
        if (fire_s) begin
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; clear wins over any strobe in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            weight_q    <= '0;
            feature_q   <= '0;
            fill_q      <= {CNT_W{1'b0}};
            s0_valid_q  <= 1'b0;
            s0_acc_q    <= 1'b0;
            p_valid_q   <= 1'b0;
            p_acc_q     <= 1'b0;
            prod_q      <= '0;
            out_valid_q <= 1'b0;
        end else if (clear) begin
            weight_q    <= '0;
            feature_q   <= '0;
            fill_q      <= {CNT_W{1'b0}};
            s0_valid_q  <= 1'b0;
            s0_acc_q    <= 1'b0;
            p_valid_q   <= 1'b0;
            p_acc_q     <= 1'b0;
            prod_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            weight_q    <= weight_d;
            feature_q   <= feature_d;
            fill_q      <= fill_d;
            s0_valid_q  <= s0_valid_d;
            s0_acc_q    <= s0_acc_d;
            p_valid_q   <= p_valid_d;
            p_acc_q     <= p_acc_d;
            prod_q      <= prod_d;
            out_valid_q <= out_valid_d;
        end
    end

    mac_sum_tree #(
        .PW    (PW),
        .TAPS  (TAPS),
        .OUT_W (OUT_W)
    ) u_sum_tree (
        .clk_i   (clk),
        .rst_n_i (rst),
        .clear_i (clear),
        .fire_i  (fire_s),
        .acc_i   (p_acc_q),
        .prod_i  (prod_q),
        .sum_o   (out)
    );

    assign out_valid = out_valid_q;
    assign if_rdy    = ~stall_s;

endmodule

// File: tb/tb_mac_stream.sv
// Self-checking bench for mac_stream (DATA_BIT=16, TAPS=3): a reference model pushes
// expected results at issue time; a monitor pops them at each output handoff.
module tb_mac_stream;

    logic        clk = 1'b0;
    logic        rst, clear, w_w, if_w, acc_en, out_ready;
    logic        if_rdy, out_valid;
    logic [15:0] w_in, if_in;
    logic [35:0] out;

    always #5 clk = ~clk;

    mac_stream #(.DATA_BIT(16), .TAPS(3), .ACC_GUARD(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .w_w       (w_w),
        .w_in      (w_in),
        .if_w      (if_w),
        .if_in     (if_in),
        .acc_en    (acc_en),
        .if_rdy    (if_rdy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    int                 n_checks = 0;
    int                 n_fail   = 0;
    logic [35:0]        sb_q[$];
    logic signed [15:0] wm[3];
    logic signed [15:0] fm[3];
    int                 fill_m;
    logic [35:0]        out_m;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < 3; i++) begin
            wm[i] = 16'sd0;
            fm[i] = 16'sd0;
        end
        fill_m = 0;
        out_m  = 36'd0;
        sb_q.delete();
    endtask

    // One clock: drive strobes, update the model at the edge (acc_ok = feature expected accepted).
    task automatic step(input logic ww, input logic [15:0] wv, input logic fw,
                        input logic [15:0] fv, input logic acc, input logic acc_ok);
        longint s;
        w_w = ww; w_in = wv; if_w = fw; if_in = fv; acc_en = acc;
        @(posedge clk);
        if (ww) begin
            wm[2] = wm[1]; wm[1] = wm[0]; wm[0] = wv;
        end
        if (fw && acc_ok) begin
            fm[2] = fm[1]; fm[1] = fm[0]; fm[0] = fv;
            if (fill_m < 3) fill_m++;
            if (fill_m == 3) begin
                s = 0;
                for (int i = 0; i < 3; i++) s += longint'(wm[i]) * longint'(fm[i]);
                out_m = acc ? out_m + 36'(s) : 36'(s);
                sb_q.push_back(out_m);
            end
        end
        #1;
        w_w = 1'b0; if_w = 1'b0; acc_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic feat(input logic [15:0] v, input logic acc);
        step(1'b0, 16'd0, 1'b1, v, acc, 1'b1);
    endtask

    // Scoreboard: every handoff must match the oldest expected result.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", 64'd1, 64'd0);
            end else begin
                chk("sb_out", out, sb_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b0; clear = 1'b0; w_w = 1'b0; if_w = 1'b0; acc_en = 1'b0;
        out_ready = 1'b1; w_in = 16'd0; if_in = 16'd0;
        model_zero();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", out, 36'd0);
        chk("reset_valid", out_valid, 1'b0);
        chk("reset_rdy", if_rdy, 1'b1);
        rst = 1'b1;

        // Basic window and 2-cycle latency
        for (int i = 1; i <= 3; i++) step(1'b1, 16'(i), 1'b0, 16'd0, 1'b0, 1'b0);
        feat(16'd4, 1'b0);
        feat(16'd5, 1'b0);
        feat(16'd6, 1'b0);
        chk("lat_k0", out_valid, 1'b0);
        idle(1);
        chk("lat_k1", out_valid, 1'b0);
        idle(1);
        chk("lat_k2", out_valid, 1'b1);
        chk("basic_out", out, 36'd32);

        // Slide and accumulate
        feat(16'd7, 1'b0);
        idle(2);
        chk("slide_out", out, 36'd38);
        feat(16'd8, 1'b1);
        idle(2);
        chk("acc_out", out, 36'd82);

        // Most negative operands
        for (int i = 0; i < 3; i++) step(1'b1, 16'h8000, 1'b0, 16'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) feat(16'h8000, 1'b0);
        idle(2);
        chk("neg_out", out, 36'd3221225472);

        // Backpressure: pending result stalls input, dropped features leave fill unchanged
        idle(1);
        out_ready = 1'b0;
        feat(16'd11, 1'b0);
        idle(2);
        chk("stall_rdy", if_rdy, 1'b0);
        step(1'b0, 16'd0, 1'b1, 16'd9, 1'b0, 1'b0);
        chk("stall_rdy9", if_rdy, 1'b0);
        step(1'b0, 16'd0, 1'b1, 16'd10, 1'b0, 1'b0);
        chk("stall_hold", out, out_m);
        chk("stall_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        idle(1);
        chk("release_rdy", if_rdy, 1'b1);
        chk("release_valid", out_valid, 1'b0);
        feat(16'd12, 1'b1);
        idle(2);
        chk("release_fill", out, out_m);

        // Clear beats simultaneous strobes
        idle(1);
        clear = 1'b1; w_w = 1'b1; if_w = 1'b1; w_in = 16'd5; if_in = 16'd5;
        @(posedge clk);
        model_zero();
        #1;
        clear = 1'b0; w_w = 1'b0; if_w = 1'b0;
        chk("clear_out", out, 36'd0);
        chk("clear_valid", out_valid, 1'b0);
        chk("clear_rdy", if_rdy, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 16'd1, 1'b0, 16'd0, 1'b0, 1'b0);
        feat(16'd1, 1'b0);
        feat(16'd2, 1'b0);
        idle(3);
        chk("clear_nowin", out_valid, 1'b0);
        feat(16'd3, 1'b0);
        idle(2);
        chk("clear_first", out, 36'd6);

        // Back-to-back windows, then asynchronous reset while they are in flight
        feat(16'd2, 1'b0);
        feat(16'd3, 1'b1);
        feat(16'd4, 1'b1);
        feat(16'd5, 1'b0);
        rst = 1'b0;
        #1;
        chk("mid_rst_out", out, 36'd0);
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_rdy", if_rdy, 1'b1);
        model_zero();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 16'd2, 1'b0, 16'd0, 1'b0, 1'b0);
        feat(16'd1, 1'b0);
        feat(16'd1, 1'b0);
        idle(3);
        chk("rst_nowin", out_valid, 1'b0);
        feat(16'd1, 1'b0);
        idle(2);
        chk("rst_first", out, 36'd6);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        chk("sb_drain", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
